wash_run: RTL and testbench

- Consumer side of the pre-stage handoff. Accepts the confirmed start pulse together with balance, mode and weight.
- Charges the wash price from the BCD balance, then sequences WASH, RINSE and SPIN phases with per-second countdown.
- Pauses while the lid is open and signals completion back to the pre-stage, which then returns to balance entry.
- Outputs BCD digits and status flags for one scan4 display instance and the state LEDs.

---
 rtl/wash_pkg.sv | 106 ++++++++++
 rtl/wash_run_tick_gen.sv | 27 ++
 rtl/wash_run.sv | 209 ++++++++++++++++++++
 tb/tb_wash_run.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared types, price/duration tables and BCD helpers for the wash run.
// No ports: imported by wash_run and wash_run_tick_gen.
package wash_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHARGE,
    S_WASH,
    S_RINSE,
    S_SPIN,
    S_FINISH,
    S_ERR
  } state_t;

  localparam logic [7:0] HEAVY_WEIGHT = 8'h20;
  localparam logic [7:0] HEAVY_EXTRA  = 8'h05;

  function automatic logic [11:0] price(
    input logic [1:0] m
  );
    logic [11:0] p;
    case (m)
      2'd0:    p = 12'h010;
      2'd1:    p = 12'h020;
      2'd2:    p = 12'h030;
      default: p = 12'h015;
    endcase
    return p;
  endfunction

  // idx: 0 wash, 1 rinse, 2 spin
  function automatic logic [7:0] dur(
    input logic [1:0] m,
    input logic [1:0] idx
  );
    logic [7:0] d;
    case ({m, idx})
      4'b00_00: d = 8'h06;
      4'b00_01: d = 8'h04;
      4'b00_10: d = 8'h03;
      4'b01_00: d = 8'h10;
      4'b01_01: d = 8'h06;
      4'b01_10: d = 8'h05;
      4'b10_00: d = 8'h15;
      4'b10_01: d = 8'h08;
      4'b10_10: d = 8'h06;
      4'b11_10: d = 8'h08;
      default:  d = 8'h00;
    endcase
    return d;
  endfunction

  // Valid BCD orders the same way as plain binary.
  function automatic logic bcd_ge3(
    input logic [11:0] a,
    input logic [11:0] b
  );
    return a >= b;
  endfunction

  function automatic logic [11:0] bcd_sub3(
    input logic [11:0] a,
    input logic [11:0] b
  );
    logic [11:0] r;
    logic [4:0]  d;
    logic        br;
    r  = '0;
    br = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = {1'b0, a[i*4 +: 4]}
        - {1'b0, b[i*4 +: 4]}
        - {4'd0, br};
      // negative digit: add ten, borrow
      br = d[4];
      if (br) d = d + 5'd10;
      r[i*4 +: 4] = d[3:0];
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_add2(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [4:0] lo;
    logic [3:0] hi;
    lo = {1'b0, a[3:0]} + {1'b0, b[3:0]};
    hi = a[7:4] + b[7:4];
    if (lo > 5'd9) begin
      lo = lo - 5'd10;
      hi = hi + 4'd1;
    end
    return {hi, lo[3:0]};
  endfunction

  function automatic logic [7:0] bcd_dec2(
    input logic [7:0] a
  );
    logic [7:0] r;
    if (a[3:0] == 4'd0) r = {a[7:4] - 4'd1, 4'd9};
    else                r = {a[7:4], a[3:0] - 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/wash_run_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
// Ports: clk, rst, en (count), clr (restart at 0), tick.
module wash_run_tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // disabled cycles hold cnt so a pause resumes mid-second
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (tick)  cnt <= '0;
    else if (en)    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/wash_run.sv
// Wash cycle runner: charge, WASH/RINSE/SPIN countdown, alarm, done.
// Ports: clk, rst, start, bal_in, mode, weight, lid_open, abort ->
//        bal_out, busy, done, err, paused, phase_led, sec_bcd, blink.
module wash_run
  import wash_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int ALARM_S  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] bal_in,
  input  logic [1:0]  mode,
  input  logic [7:0]  weight,
  input  logic        lid_open,
  input  logic        abort,
  output logic [11:0] bal_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        paused,
  output logic [2:0]  phase_led,
  output logic [7:0]  sec_bcd,
  output logic        blink
);

  localparam int AW = (ALARM_S > 1) ? $clog2(ALARM_S + 1) : 1;
  localparam logic [AW-1:0] A_LAST = AW'(ALARM_S - 1);

  state_t state, state_n;

  logic [11:0]   bal_q;
  logic [1:0]    mode_q;
  logic [7:0]    weight_q;
  logic [AW-1:0] acnt, acnt_n;
  logic [11:0]   bal_n;
  logic [7:0]    sec_n;
  logic          busy_n, done_n, blink_n;
  logic          take, in_ph, alarm, tick, tg_en, tg_clr;

  function automatic logic [7:0] ph_dur(
    input state_t     s,
    input logic [1:0] m,
    input logic [7:0] w
  );
    logic [7:0] d;
    case (s)
      S_WASH: begin
        d = dur(m, 2'd0);
        if (d != 8'h00 && w >= HEAVY_WEIGHT)
          d = bcd_add2(d, HEAVY_EXTRA);
      end
      S_RINSE: d = dur(m, 2'd1);
      S_SPIN:  d = dur(m, 2'd2);
      default: d = 8'h00;
    endcase
    return d;
  endfunction

  // first later phase with nonzero duration, else FINISH
  function automatic state_t next_ph(
    input state_t     s,
    input logic [1:0] m
  );
    state_t r;
    r = S_FINISH;
    if (s == S_CHARGE && dur(m, 2'd0) != 8'h00)
      r = S_WASH;
    else if ((s == S_CHARGE || s == S_WASH)
             && dur(m, 2'd1) != 8'h00)
      r = S_RINSE;
    else if (s != S_SPIN && s != S_FINISH
             && dur(m, 2'd2) != 8'h00)
      r = S_SPIN;
    return r;
  endfunction

  assign in_ph = (state == S_WASH) || (state == S_RINSE)
              || (state == S_SPIN);
  assign alarm = (state == S_FINISH) || (state == S_ERR);
  assign take  = (state == S_IDLE) && start && !done;

  assign tg_en  = (in_ph && !lid_open) || alarm;
  assign tg_clr = (state_n != state);

  wash_run_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tg_en),
    .clr  (tg_clr),
    .tick (tick)
  );

  assign err    = (state == S_ERR);
  assign paused = in_ph && lid_open;

  always_comb begin
    phase_led = 3'b000;
    unique case (1'b1)
      (state == S_WASH):  phase_led = 3'b001;
      (state == S_RINSE): phase_led = 3'b010;
      (state == S_SPIN):  phase_led = 3'b100;
      default:            phase_led = 3'b000;
    endcase
  end

  always_comb begin
    state_n = state;
    bal_n   = bal_out;
    sec_n   = sec_bcd;
    busy_n  = busy;
    done_n  = 1'b0;
    blink_n = blink;
    acnt_n  = acnt;
    case (state)
      S_IDLE: begin
        if (take) begin
          state_n = S_CHARGE;
          busy_n  = 1'b1;
        end
      end
      S_CHARGE: begin
        if (abort) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end else if (bcd_ge3(bal_q, price(mode_q))) begin
          bal_n   = bcd_sub3(bal_q, price(mode_q));
          state_n = next_ph(S_CHARGE, mode_q);
          sec_n   = ph_dur(state_n, mode_q, weight_q);
          acnt_n  = '0;
          blink_n = 1'b0;
        end else begin
          bal_n   = bal_q;
          state_n = S_ERR;
          sec_n   = 8'h00;
          acnt_n  = '0;
          blink_n = 1'b0;
        end
      end
      S_WASH, S_RINSE, S_SPIN: begin
        if (abort) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          sec_n   = 8'h00;
        end else if (tick) begin
          if (sec_bcd == 8'h01) begin
            state_n = next_ph(state, mode_q);
            sec_n   = ph_dur(state_n, mode_q, weight_q);
            acnt_n  = '0;
            blink_n = 1'b0;
          end else begin
            sec_n = bcd_dec2(sec_bcd);
          end
        end
      end
      S_FINISH, S_ERR: begin
        if (tick) begin
          if (acnt == A_LAST) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            blink_n = 1'b0;
          end else begin
            acnt_n  = acnt + 1'b1;
            blink_n = ~blink;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bal_out  <= '0;
      sec_bcd  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      blink    <= 1'b0;
      acnt     <= '0;
      bal_q    <= '0;
      mode_q   <= '0;
      weight_q <= '0;
    end else begin
      state   <= state_n;
      bal_out <= bal_n;
      sec_bcd <= sec_n;
      busy    <= busy_n;
      done    <= done_n;
      blink   <= blink_n;
      acnt    <= acnt_n;
      if (take) begin
        bal_q    <= bal_in;
        mode_q   <= mode;
        weight_q <= weight;
      end
    end
  end

endmodule

// File: tb/tb_wash_run.sv
// Bench for wash_run: directed scenarios plus random runs
// against a timeline model built from prices and durations.
module tb_wash_run;

  localparam int TD = 4;
  localparam int AS = 3;

  logic        clk = 1'b0;
  logic        rst, start, lid_open, abort;
  logic [11:0] bal_in;
  logic [1:0]  mode;
  logic [7:0]  weight;
  logic [11:0] bal_out;
  logic        busy, done, err, paused, blink;
  logic [2:0]  phase_led;
  logic [7:0]  sec_bcd;

  int errors = 0;
  int checks = 0;

  int PRICE [4]    = '{10, 20, 30, 15};
  int DUR   [4][3] = '{'{6, 4, 3}, '{10, 6, 5},
                       '{15, 8, 6}, '{0, 0, 8}};

  wash_run #(.TICK_DIV(TD), .ALARM_S(AS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bal_in    (bal_in),
    .mode      (mode),
    .weight    (weight),
    .lid_open  (lid_open),
    .abort     (abort),
    .bal_out   (bal_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .paused    (paused),
    .phase_led (phase_led),
    .sec_bcd   (sec_bcd),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [11:0] a);
    return int'(a[11:8]) * 100 + int'(a[7:4]) * 10
         + int'(a[3:0]);
  endfunction

  function automatic logic [11:0] int2bcd3(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] int2bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bal"},   32'(bal_out), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_err"},   32'(err), 0);
    chk({tag, "_pause"}, 32'(paused), 0);
    chk({tag, "_led"},   32'(phase_led), 0);
    chk({tag, "_sec"},   32'(sec_bcd), 0);
    chk({tag, "_blink"}, 32'(blink), 0);
  endtask

  // One full cycle. lid_s: wash second at which lid opens
  // for 10 cycles; ab_ph/ab_s: abort point; rs_ph/rs_s: reset.
  task automatic run(input logic [11:0] bal,
                     input logic [1:0]  m,
                     input logic [7:0]  w,
                     input int lid_s,
                     input int ab_ph, input int ab_s,
                     input int rs_ph, input int rs_s);
    int b, p, d[3];
    bit ok;
    logic [11:0] eb;
    b  = bcd2int(bal);
    p  = PRICE[m];
    ok = (b >= p);
    eb = ok ? int2bcd3(b - p) : bal;
    for (int i = 0; i < 3; i++) d[i] = DUR[m][i];
    if (int'(w[7:4]) * 10 + int'(w[3:0]) >= 20 && d[0] != 0)
      d[0] += 5;

    bal_in = bal; mode = m; weight = w;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_acc", 32'(busy), 1);
    chk("led_chg", 32'(phase_led), 0);
    step();
    chk("bal_out", 32'(bal_out), 32'(eb));
    chk("err_flag", 32'(err), 32'(!ok));

    if (ok) begin
      for (int ph = 0; ph < 3; ph++) begin
        for (int s = d[ph]; s >= 1; s--) begin
          for (int c = 0; c < TD; c++) begin
            chk("led", 32'(phase_led), 32'(1 << ph));
            chk("sec", 32'(sec_bcd), 32'(int2bcd2(s)));
            chk("busy_run", 32'(busy), 1);
            chk("pause_run", 32'(paused), 0);
            if (ph == ab_ph && s == ab_s && c == 1) begin
              abort = 1'b1;
              step();
              abort = 1'b0;
              chk("ab_done", 32'(done), 1);
              chk("ab_busy", 32'(busy), 0);
              chk("ab_led", 32'(phase_led), 0);
              chk("ab_bal", 32'(bal_out), 32'(eb));
              start = 1'b1;
              step();
              start = 1'b0;
              chk("ab_ign_busy", 32'(busy), 0);
              chk("ab_ign_done", 32'(done), 0);
              return;
            end
            if (ph == rs_ph && s == rs_s && c == 2) begin
              rst = 1'b1;
              start = 1'b1;
              step();
              chk_reset_vals("rst_mid");
              rst = 1'b0;
              start = 1'b0;
              step();
              chk("rst_start_ign", 32'(busy), 0);
              return;
            end
            if (ph == 0 && s == lid_s && c == 1) begin
              lid_open = 1'b1;
              for (int k = 0; k < 10; k++) begin
                step();
                chk("lid_pause", 32'(paused), 1);
                chk("lid_sec", 32'(sec_bcd),
                    32'(int2bcd2(s)));
              end
              lid_open = 1'b0;
            end
            step();
          end
        end
      end
    end

    for (int k = 0; k < AS; k++) begin
      for (int c = 0; c < TD; c++) begin
        chk("al_led", 32'(phase_led), 0);
        chk("al_sec", 32'(sec_bcd), 0);
        chk("al_blink", 32'(blink), 32'(k % 2));
        chk("al_err", 32'(err), 32'(!ok));
        chk("al_done", 32'(done), 0);
        chk("al_busy", 32'(busy), 1);
        step();
      end
    end
    chk("end_done", 32'(done), 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_err", 32'(err), 0);
    chk("end_blink", 32'(blink), 0);
    step();
    chk("end_done1", 32'(done), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; lid_open = 1'b0; abort = 1'b0;
    bal_in = '0; mode = '0; weight = '0;
    step();
    step();
    chk_reset_vals("reset");
    rst = 1'b0;
    step();

    run(12'h045, 2'd1, 8'h12, 0, -1, 0, -1, 0);
    run(12'h009, 2'd0, 8'h05, 0, -1, 0, -1, 0);
    run(12'h100, 2'd3, 8'h25, 0, -1, 0, -1, 0);
    run(12'h200, 2'd2, 8'h20, 17, -1, 0, -1, 0);
    run(12'h050, 2'd1, 8'h05, 0, 1, 3, -1, 0);
    run(12'h030, 2'd0, 8'h00, 0, -1, 0, -1, 0);
    run(12'h099, 2'd0, 8'h07, 0, -1, 0, 2, 2);
    chk_reset_vals("after_rst");

    for (int r = 0; r < 10; r++) begin
      logic [1:0]  rm;
      logic [7:0]  rw;
      logic [11:0] rb;
      rm = 2'($urandom_range(0, 3));
      rw = int2bcd2(int'($urandom_range(0, 29)));
      rb = int2bcd3(int'($urandom_range(0, 60)));
      run(rb, rm, rw, 0, -1, 0, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
